coleta_senha: RTL and testbench
===============================

Name: coleta_senha

Overview:
- Keypad-side producer for the electronic lock.
- Collects key events (digits 0-9, '*' backspace, '#' confirm) and assembles them into a senhaPac_t.
- On confirm, emits a one-cycle senha_pronta strobe that drives the enable input of validaSenha.
- Owns entry rules: minimum and maximum length, inactivity timeout, external lockout.

Parameters:
- MIN_DIG, 4, minimum digits accepted on '#'.
- TIMEOUT_CYC, 50000, clk cycles without an accepted key before the entry is discarded (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- tecla_valida  in  1  one-cycle strobe, tecla_cod is valid.
- tecla_cod  in  4  0x0-0x9 digit; 0xA '*'; 0xB '#'; 0xC-0xF reserved/ignored.
- bloqueio  in  1  lockout from the lock controller; keys ignored while 1.
- senha_out  out  senhaPac_t  assembled password, goes to validaSenha.senha_input.
- senha_pronta  out  1  one-cycle strobe, senha_out valid; goes to validaSenha.enable.
- erro_tamanho  out  1  one-cycle strobe, '#' pressed with fewer than MIN_DIG digits.
- timeout  out  1  one-cycle strobe, entry discarded by inactivity.
- entrada_ativa  out  1  high while in COLETA.

Behaviour:
- Reset (rst=0, async): state IDLE; senha_out all zero (len=0, digits=0); all strobes 0; timer 0.
- FSM states: IDLE, COLETA, ENVIA. All outputs are registered.
- IDLE:
  - Digit d: clear senha_out; set digits[0]=d, len=1; go to COLETA; timer=0.
  - '*', '#', reserved codes: ignored.
  - senha_out holds its last value until the first digit of a new entry.
- COLETA:
  - Digit: if len<SENHA_MAX, store at digits[len] and increment len. Otherwise drop it silently. Either way timer=0.
  - '*': if len>1, zero digits[len-1] and decrement len. If len==1, clear senha_out and go to IDLE. Timer=0.
  - '#': if len≥MIN_DIG, go to ENVIA. Otherwise pulse erro_tamanho for 1 cycle, clear senha_out, go to IDLE.
  - No valid key in a cycle: timer increments. When timer==TIMEOUT_CYC-1, pulse timeout, clear senha_out, go to IDLE.
  - Reserved codes do not reset the timer.
- ENVIA (1 cycle): senha_pronta=1; senha_out stable; tecla_valida ignored; next state IDLE.
  - Latency: senha_pronta rises the cycle after the '#' sample.
- bloqueio=1 has priority over any key in the same cycle. In COLETA: discard the entry (clear senha_out) and go to IDLE, with no strobes. In ENVIA: the strobe completes. In IDLE: nothing.
- Timeout and key in the same cycle: the key wins and the timer resets.
- Unused digit positions are always zero, so validaSenha may compare the full packed value.
- Strobes are mutually exclusive; at most one is high in any cycle.

Optional Feature:
- Macro: SENHA_FEEDBACK_EN.
- Defined: adds output tecla_aceita (1 bit), which pulses one cycle after every key that changed state or senha_out. Includes a digit stored, a '*' that removed a digit, and '#'. Dropped overflow digits and ignored keys do not pulse.
- Also adds output n_digitos (5 bits), equal to the current len, for the display.
- Undefined: both ports are absent. Core behaviour is identical.

Decomposition:
- Package Tipos.sv holds:
  - SENHA_MAX = 12.
  - digito_t = logic[3:0].
  - senhaPac_t = packed struct {digito_t [SENHA_MAX-1:0] digits; logic[4:0] len}.
  - Key code constants TECLA_AST = 4'hA and TECLA_HASH = 4'hB.
  - FSM enum estado_coleta_t.
- Sub-module timer_inatividade (parameter TIMEOUT_CYC; ports clr, en, expira) holds the inactivity counter. All other logic stays in coleta_senha.

Test Plan:
- Keys 1,2,3,4,'#' → senha_pronta for exactly 1 cycle, the cycle after '#'; senha_out.len=4, digits[3:0]=4,3,2,1, other digits 0.
- Keys 5,6,'#' (MIN_DIG=4) → erro_tamanho 1 cycle, no senha_pronta, state IDLE, senha_out zero.
- Keys 1,2,'*',3,'*','*' → after 1,2,'*',3: len=2, digits 1,3; final '*' returns to IDLE with senha_out zero.
- 13 digits 0..9,0,1,2 then '#' → len=12; the 13th digit (2) is dropped; senha_pronta asserted.
- Key 7 then no keys for TIMEOUT_CYC (set to 8) cycles → timeout pulses on the 8th idle cycle, entrada_ativa falls, senha_out zero.
- Keys 1,2,3, then bloqueio=1 with '#' in the same cycle → no strobes, IDLE. Also: rst=0 in the middle of an entry → all outputs zero immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/Tipos.sv
// Tipos: shared types and constants for the keypad password producer.
//   SENHA_MAX       maximum digits held in a password packet
//   digito_t        one BCD key digit
//   senhaPac_t      packed password: digits[SENHA_MAX-1:0] plus len
//   TECLA_AST/HASH  key codes for backspace and confirm
//   estado_coleta_t collection FSM states
package Tipos;

    localparam int SENHA_MAX = 12;

    typedef logic [3:0] digito_t;

    typedef struct packed {
        digito_t [SENHA_MAX-1:0] digits;
        logic [4:0]              len;
    } senhaPac_t;

    localparam digito_t TECLA_AST  = 4'hA;
    localparam digito_t TECLA_HASH = 4'hB;

    typedef enum logic [1:0] {
        IDLE,
        COLETA,
        ENVIA
    } estado_coleta_t;

endpackage

// File: rtl/coleta_senha_timer.sv
// timer_inatividade: inactivity counter for password entry.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : zero the counter (has priority over en)
//   en       : count one idle cycle
//   expira   : counter has reached TIMEOUT_CYC-1
module timer_inatividade #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expira
);

    localparam int W = $clog2(TIMEOUT_CYC);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign expira = (count == W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/coleta_senha.sv
// coleta_senha: collects keypad events into a password packet for validaSenha.
//   clk, rst      : clock, asynchronous active-low reset
//   tecla_valida  : one-cycle strobe qualifying tecla_cod
//   tecla_cod     : 0-9 digit, 0xA backspace, 0xB confirm, 0xC-0xF ignored
//   bloqueio      : lockout; keys ignored and a running entry discarded
//   senha_out     : assembled password (unused positions always zero)
//   senha_pronta  : one-cycle strobe, senha_out valid
//   erro_tamanho  : one-cycle strobe, confirm with fewer than MIN_DIG digits
//   timeout       : one-cycle strobe, entry discarded by inactivity
//   entrada_ativa : high while collecting
// Optional (macro SENHA_FEEDBACK_EN): tecla_aceita pulse per effective key,
// n_digitos current length.
module coleta_senha
    import Tipos::*;
#(
    parameter int MIN_DIG     = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tecla_valida,
    input  logic [3:0] tecla_cod,
    input  logic       bloqueio,
    output senhaPac_t  senha_out,
    output logic       senha_pronta,
    output logic       erro_tamanho,
    output logic       timeout,
    output logic       entrada_ativa
`ifdef SENHA_FEEDBACK_EN
    ,
    output logic       tecla_aceita,
    output logic [4:0] n_digitos
`endif
);

    localparam logic [4:0] LEN_MAX = 5'(SENHA_MAX);
    localparam logic [4:0] LEN_MIN = 5'(MIN_DIG);

    estado_coleta_t state, state_n;
    senhaPac_t      senha_n;
    logic           pronta_n, erro_n, timeout_n;
    logic           key_ok, is_dig;
    logic           timer_clr, timer_en, timer_expira;

    timer_inatividade #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .expira(timer_expira)
    );

    assign key_ok = tecla_valida && (tecla_cod <= TECLA_HASH);
    assign is_dig = (tecla_cod <= 4'h9);

    always_comb begin
        state_n   = state;
        senha_n   = senha_out;
        pronta_n  = 1'b0;
        erro_n    = 1'b0;
        timeout_n = 1'b0;
        timer_clr = 1'b1;
        timer_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!bloqueio && tecla_valida && is_dig) begin
                    senha_n            = '0;
                    senha_n.digits[0]  = tecla_cod;
                    senha_n.len        = 5'd1;
                    state_n            = COLETA;
                end
            end
            COLETA: begin
                if (bloqueio) begin
                    senha_n = '0;
                    state_n = IDLE;
                end else if (key_ok) begin
                    if (is_dig) begin
                        if (senha_out.len < LEN_MAX) begin
                            for (int unsigned i = 0; i < SENHA_MAX; i++) begin
                                if (5'(i) == senha_out.len) senha_n.digits[i] = tecla_cod;
                            end
                            senha_n.len = senha_out.len + 5'd1;
                        end
                    end else if (tecla_cod == TECLA_AST) begin
                        if (senha_out.len > 5'd1) begin
                            for (int unsigned i = 0; i < SENHA_MAX; i++) begin
                                if (5'(i) == senha_out.len - 5'd1) senha_n.digits[i] = '0;
                            end
                            senha_n.len = senha_out.len - 5'd1;
                        end else begin
                            senha_n = '0;
                            state_n = IDLE;
                        end
                    end else begin
                        if (senha_out.len >= LEN_MIN) begin
                            pronta_n = 1'b1;
                            state_n  = ENVIA;
                        end else begin
                            erro_n  = 1'b1;
                            senha_n = '0;
                            state_n = IDLE;
                        end
                    end
                end else if (timer_expira) begin
                    timeout_n = 1'b1;
                    senha_n   = '0;
                    state_n   = IDLE;
                end else begin
                    timer_clr = 1'b0;
                    timer_en  = 1'b1;
                end
            end
            ENVIA: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            senha_out     <= '0;
            senha_pronta  <= 1'b0;
            erro_tamanho  <= 1'b0;
            timeout       <= 1'b0;
            entrada_ativa <= 1'b0;
        end else begin
            state         <= state_n;
            senha_out     <= senha_n;
            senha_pronta  <= pronta_n;
            erro_tamanho  <= erro_n;
            timeout       <= timeout_n;
            entrada_ativa <= (state_n == COLETA);
        end
    end

`ifdef SENHA_FEEDBACK_EN
    // A key is "accepted" exactly when it moved the FSM or edited the packet;
    // lockout and the ENVIA cycle never count.
    logic aceita_n;
    assign aceita_n = (state != ENVIA) && !bloqueio && key_ok &&
                      ((state_n != state) || (senha_n != senha_out));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tecla_aceita <= 1'b0;
        end else begin
            tecla_aceita <= aceita_n;
        end
    end

    assign n_digitos = senha_out.len;
`endif

endmodule

// File: tb/tb_coleta_senha.sv
// tb_coleta_senha: self-checking bench for coleta_senha with a queue-based
// reference model of the password entry rules.
module tb_coleta_senha;
    import Tipos::*;

    localparam int TMO = 8;
    localparam int MIN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tecla_valida = 1'b0;
    logic [3:0] tecla_cod = '0;
    logic       bloqueio = 1'b0;
    senhaPac_t  senha_out;
    logic       senha_pronta, erro_tamanho, timeout, entrada_ativa;
`ifdef SENHA_FEEDBACK_EN
    logic       tecla_aceita;
    logic [4:0] n_digitos;
`endif

    coleta_senha #(
        .MIN_DIG    (MIN),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tecla_valida (tecla_valida),
        .tecla_cod    (tecla_cod),
        .bloqueio     (bloqueio),
        .senha_out    (senha_out),
        .senha_pronta (senha_pronta),
        .erro_tamanho (erro_tamanho),
        .timeout      (timeout),
        .entrada_ativa(entrada_ativa)
`ifdef SENHA_FEEDBACK_EN
        ,
        .tecla_aceita (tecla_aceita),
        .n_digitos    (n_digitos)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the queue is the digit sequence currently shown.
    int q[$];
    bit active  = 1'b0;
    bit sending = 1'b0;
    int idle    = 0;
    bit e_pronta, e_erro, e_to, e_acc;

    task automatic model_reset();
        q.delete();
        active = 1'b0; sending = 1'b0; idle = 0;
        e_pronta = 1'b0; e_erro = 1'b0; e_to = 1'b0; e_acc = 1'b0;
    endtask

    task automatic model(input bit v, input int c, input bit b);
        e_pronta = 1'b0; e_erro = 1'b0; e_to = 1'b0; e_acc = 1'b0;
        if (sending) begin
            sending = 1'b0;
        end else if (!active) begin
            if (!b && v && c <= 9) begin
                q.delete(); q.push_back(c);
                active = 1'b1; idle = 0; e_acc = 1'b1;
            end
        end else if (b) begin
            q.delete(); active = 1'b0; idle = 0;
        end else if (v && c <= 11) begin
            idle = 0;
            if (c <= 9) begin
                if (q.size() < SENHA_MAX) begin
                    q.push_back(c); e_acc = 1'b1;
                end
            end else if (c == 10) begin
                void'(q.pop_back());
                e_acc = 1'b1;
                if (q.size() == 0) active = 1'b0;
            end else begin
                e_acc = 1'b1; active = 1'b0;
                if (q.size() >= MIN) begin
                    sending = 1'b1; e_pronta = 1'b1;
                end else begin
                    e_erro = 1'b1; q.delete();
                end
            end
        end else begin
            idle++;
            if (idle == TMO) begin
                e_to = 1'b1; q.delete(); active = 1'b0; idle = 0;
            end
        end
    endtask

    function automatic senhaPac_t packed_exp();
        senhaPac_t p;
        p = '0;
        foreach (q[i]) p.digits[i] = 4'(q[i]);
        p.len = 5'(q.size());
        return p;
    endfunction

    task automatic compare_all();
        check("senha_out", 64'(senha_out), 64'(packed_exp()));
        check("senha_pronta", 64'(senha_pronta), 64'(e_pronta));
        check("erro_tamanho", 64'(erro_tamanho), 64'(e_erro));
        check("timeout", 64'(timeout), 64'(e_to));
        check("entrada_ativa", 64'(entrada_ativa), 64'(active));
        check("strobe_excl", 64'(32'(senha_pronta) + 32'(erro_tamanho) + 32'(timeout) > 1), 64'(0));
`ifdef SENHA_FEEDBACK_EN
        check("tecla_aceita", 64'(tecla_aceita), 64'(e_acc));
        check("n_digitos", 64'(n_digitos), 64'(q.size()));
`endif
    endtask

    task automatic step(input logic v, input logic [3:0] c, input logic b);
        tecla_valida = v; tecla_cod = c; bloqueio = b;
        @(posedge clk);
        model(v, int'(c), b);
        #1;
        compare_all();
        tecla_valida = 1'b0; tecla_cod = '0; bloqueio = 1'b0;
    endtask

    task automatic key(input logic [3:0] c);
        step(1'b1, c, 1'b0);
    endtask

    initial begin
        logic [3:0] seq[$];
        senhaPac_t  ref_pkt;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_senha_zero", 64'(senha_out), 64'(0));
        #3 rst = 1'b1;

        // 1,2,3,4,# -> packet sent the cycle after '#'
        seq = '{4'd1, 4'd2, 4'd3, 4'd4, TECLA_HASH};
        foreach (seq[i]) key(seq[i]);
        ref_pkt = '0;
        ref_pkt.digits[0] = 4'd1; ref_pkt.digits[1] = 4'd2;
        ref_pkt.digits[2] = 4'd3; ref_pkt.digits[3] = 4'd4;
        ref_pkt.len = 5'd4;
        check("tp1_pkt", 64'(senha_out), 64'(ref_pkt));
        check("tp1_pronta", 64'(senha_pronta), 64'(1));
        step(1'b1, 4'd9, 1'b0);                 // ignored during ENVIA
        check("tp1_pronta_end", 64'(senha_pronta), 64'(0));
        step(1'b0, 4'd0, 1'b0);                 // packet retained in IDLE

        // 5,6,# -> length error
        seq = '{4'd5, 4'd6, TECLA_HASH};
        foreach (seq[i]) key(seq[i]);
        check("tp2_erro", 64'(erro_tamanho), 64'(1));
        step(1'b0, 4'd0, 1'b0);

        // 1,2,*,3,*,*
        seq = '{4'd1, 4'd2, TECLA_AST, 4'd3};
        foreach (seq[i]) key(seq[i]);
        ref_pkt = '0;
        ref_pkt.digits[0] = 4'd1; ref_pkt.digits[1] = 4'd3; ref_pkt.len = 5'd2;
        check("tp3_pkt", 64'(senha_out), 64'(ref_pkt));
        key(TECLA_AST);
        key(TECLA_AST);
        check("tp3_idle", 64'(entrada_ativa), 64'(0));

        // 13 digits then '#': last digit dropped
        for (int i = 0; i < 13; i++) key(4'(i % 10));
        check("tp4_len", 64'(senha_out.len), 64'(12));
        key(TECLA_HASH);
        step(1'b0, 4'd0, 1'b0);

        // 7 then 8 idle cycles -> timeout
        key(4'd7);
        repeat (TMO) step(1'b0, 4'd0, 1'b0);
        check("tp5_timeout", 64'(timeout), 64'(1));
        step(1'b0, 4'd0, 1'b0);

        // reserved codes do not refresh the timer
        key(4'd3);
        repeat (TMO) step(1'b1, 4'hD, 1'b0);
        step(1'b0, 4'd0, 1'b0);

        // lockout with '#' in the same cycle
        seq = '{4'd1, 4'd2, 4'd3};
        foreach (seq[i]) key(seq[i]);
        step(1'b1, TECLA_HASH, 1'b1);
        check("tp6_blq_idle", 64'(entrada_ativa), 64'(0));

        // async reset mid-entry
        key(4'd5); key(4'd6);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check("arst_senha", 64'(senha_out), 64'(0));
        check("arst_ativa", 64'(entrada_ativa), 64'(0));
        check("arst_strobes", 64'({senha_pronta, erro_tamanho, timeout}), 64'(0));
        #2 rst = 1'b1;

        // randomized phases with varying key density
        for (int ph = 0; ph < 40; ph++) begin
            int pv;
            pv = int'($urandom_range(5, 90));
            for (int k = 0; k < 60; k++) begin
                logic       v, b;
                logic [3:0] c;
                int         r;
                v = ($urandom_range(99) < pv);
                r = int'($urandom_range(0, 19));
                if (r < 14)      c = 4'(r % 10);
                else if (r < 16) c = TECLA_AST;
                else if (r < 18) c = TECLA_HASH;
                else             c = 4'($urandom_range(12, 15));
                b = ($urandom_range(99) < 3);
                step(v, c, b);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
